// File: rtl/spi_slave_sync_if.sv
// Bus bundle between the SPI responder and its local logic / the SPI master pins.
// SPI_SLAVE_OVERRUN_EN adds rx_ack and rx_overrun.
`default_nettype none

interface spi_slave_sync_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic                  rx_ack;
  logic                  rx_overrun;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_load, rx_ack,
    output miso, tx_ready, rx_data, rx_valid, rx_overrun
  );
  modport master (
    output sclk, cs_n, mosi, tx_data, tx_load, rx_ack,
    input  miso, tx_ready, rx_data, rx_valid, rx_overrun
  );
`else
  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid
  );
  modport master (
    output sclk, cs_n, mosi, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid
  );
`endif
endinterface

`default_nettype wire

// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder oversampling sclk/cs_n/mosi in the clk domain, MSB first.
// Optional SPI_SLAVE_OVERRUN_EN: rx_ack input and sticky rx_overrun output.
`default_nettype none

module spi_slave_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  spi_slave_sync_if.slave  bus
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   primed, armed;
  state_t                 state, state_nxt;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_tx, shift_rx, tx_buf, rx_data;
  logic                   tx_full, done, rx_valid;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic start, stop, rise_act, fall_act, last_bit, reload, load_ok;
  logic [DATA_WIDTH-1:0] reload_word;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // armed only once a real (post-reset) high level of cs_n has been seen, so a
  // cs_n already low at reset release is not mistaken for a fresh select.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      primed    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      primed    <= 1'b1;
      if (primed && (&cs_sync) && cs_d) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall && armed) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start       = (state == IDLE) && (state_nxt == ACTIVE);
  assign stop        = (state == ACTIVE) && cs_rise;
  assign rise_act    = (state == ACTIVE) && !cs_rise && sclk_rise;
  assign fall_act    = (state == ACTIVE) && !cs_rise && sclk_fall;
  assign last_bit    = (bit_cnt == CW'(DATA_WIDTH-1));
  assign reload      = start || (fall_act && (bit_cnt == '0));
  assign reload_word = tx_full ? tx_buf : '0;
  // A reload frees the buffer in the same clk, so a coincident load is taken.
  assign load_ok     = bus.tx_load && (!tx_full || reload);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      shift_tx <= '0;
      shift_rx <= '0;
      tx_buf   <= '0;
      tx_full  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= done;
      if (done) rx_data <= shift_rx;

      if (start) begin
        shift_tx <= reload_word;
        bit_cnt  <= '0;
      end else if (stop) begin
        bit_cnt <= '0;
      end else if (rise_act) begin
        shift_rx <= {shift_rx[DATA_WIDTH-2:0], mosi_s};
        if (last_bit) begin
          bit_cnt <= '0;
          done    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (fall_act) begin
        if (bit_cnt != '0) shift_tx <= {shift_tx[DATA_WIDTH-2:0], 1'b0};
        else               shift_tx <= reload_word;
      end

      if (load_ok) tx_buf <= bus.tx_data;
      tx_full <= (tx_full && !reload) || load_ok;
    end
  end

  assign bus.miso     = (state == ACTIVE) && shift_tx[DATA_WIDTH-1];
  assign bus.tx_ready = !tx_full;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic unacked, overrun;

  // An ack coinciding with a completion belongs to the previous word.
  always_ff @(posedge clk) begin
    if (rst) begin
      unacked <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (done)            unacked <= 1'b1;
      else if (bus.rx_ack) unacked <= 1'b0;
      if (bus.rx_ack)            overrun <= 1'b0;
      else if (done && unacked)  overrun <= 1'b1;
    end
  end

  assign bus.rx_overrun = overrun;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: bit-level SPI master, word-level reply/receive model.
`default_nettype none

module tb_spi_slave_sync;
  localparam int W = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_sync_if #(.DATA_WIDTH(W)) bus();

  spi_slave_sync #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit track = 1'b0;

  logic [W-1:0] exp_rx[$];
  logic [W-1:0] exp_miso[$];

  // Reply model: a one-word buffer consumed at each select and each word end.
  logic [W-1:0] m_buf  = '0;
  bit           m_full = 1'b0;

  function automatic logic [W-1:0] take();
    take   = m_full ? m_buf : '0;
    m_full = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    if (!m_full) begin
      m_buf  = v;
      m_full = 1'b1;
    end
    wait_clk(1);
    bus.tx_load = 1'b0;
  endtask

  // One chip-select frame; the last word may be cut short to last_bits.
  task automatic xfer(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                      input int nw, input int last_bits, input int half,
                      input int nld, input logic [W-1:0] ld0, input logic [W-1:0] ld1);
    logic [W-1:0] reply, word;
    int nb;
    bus.cs_n = 1'b0;
    reply = take();
    for (int i = 0; i < nw; i++) begin
      word = (i == 0) ? w0 : (i == 1) ? w1 : w2;
      nb   = (i == nw - 1) ? last_bits : W;
      if (nb == W) begin
        exp_miso.push_back(reply);
        exp_rx.push_back(word);
      end
      for (int b = 0; b < nb; b++) begin
        bus.mosi = word[W-1-b];
        wait_clk(half);
        bus.sclk = 1'b1;
        wait_clk(half);
        bus.sclk = 1'b0;
        if (i == 0 && b == 3) begin
          if (nld > 0) do_load(ld0);
          if (nld > 1) do_load(ld1);
        end
      end
      if (nb == W) reply = take();
    end
    wait_clk(half);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    wait_clk(half + S + 4);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: master-side miso capture and rx_valid checking against the queues.
  initial begin
    logic         prev_sclk, prev_cs;
    logic [W-1:0] macc;
    int           mbits, last_rise;
    prev_sclk = 1'b0; prev_cs = 1'b1; macc = '0; mbits = 0; last_rise = 0;
    forever begin
      @(negedge clk);
      if (track) begin
        if (bus.cs_n && !prev_cs) mbits = 0;
        if (bus.sclk && !prev_sclk && !bus.cs_n) begin
          macc      = {macc[W-2:0], bus.miso};
          last_rise = cyc;
          mbits++;
          if (mbits == W) begin
            mbits = 0;
            if (exp_miso.size() == 0) fail("miso_unexpected_word");
            else chk("miso_word", macc, exp_miso.pop_front());
          end
        end
      end
      if (bus.rx_valid === 1'b1) begin
        if (exp_rx.size() == 0) fail("rx_valid_unexpected");
        else begin
          chk("rx_data", bus.rx_data, exp_rx.pop_front());
          chk("rx_latency", cyc - last_rise, S + 2);
        end
      end
      prev_sclk = bus.sclk;
      prev_cs   = bus.cs_n;
    end
  end

  initial begin
    logic [W-1:0] a, b, c;
    int nw, lb, hf, nl;

    // Reset with random pin activity
    rst = 1'b1;
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_load = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    bus.rx_ack = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      bus.sclk    = 1'($urandom);
      bus.cs_n    = 1'($urandom);
      bus.mosi    = 1'($urandom);
      bus.tx_data = W'($urandom);
      bus.tx_load = 1'($urandom);
      @(negedge clk);
      chk("reset_miso", bus.miso, 0);
      chk("reset_tx_ready", bus.tx_ready, 1);
      chk("reset_rx_data", bus.rx_data, 0);
      chk("reset_rx_valid", bus.rx_valid, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
      chk("reset_rx_overrun", bus.rx_overrun, 0);
`endif
    end
    @(posedge clk); #2;
    rst = 1'b0;
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0; bus.tx_load = 1'b0;
    wait_clk(6);
    track = 1'b1;

    // Single word: reply 0xA5, receive 0x3C at a 16-clk SCLK period
    do_load(8'hA5);
    chk("tx_ready_after_load", bus.tx_ready, 0);
    xfer(8'h3C, '0, '0, 1, W, 8, 0, '0, '0);
    chk("tx_ready_after_cs", bus.tx_ready, 1);

    // Back-to-back words with a reload word loaded mid-frame
    do_load(8'hC3);
    xfer(8'h11, 8'h22, '0, 2, W, 6, 1, 8'h5A, '0);

    // Aborted word leaves rx_data untouched
    xfer(8'hFF, '0, '0, 1, 5, 5, 0, '0, '0);
    chk("rx_data_after_abort", bus.rx_data, 8'h22);
    xfer(8'h81, '0, '0, 1, W, 7, 0, '0, '0);
    chk("rx_data_after_81", bus.rx_data, 8'h81);

    // Empty buffer replies zeros; only the first of two mid-frame loads lands
    xfer(8'h6E, 8'h93, '0, 2, W, 5, 2, 8'hB7, 8'h4D);
    chk("tx_ready_end_empty", bus.tx_ready, 1);

    // Reset mid-transfer while cs_n stays low: no word until a fresh select
    track = 1'b0;
    do_load(8'hE1);
    bus.cs_n = 1'b0;
    wait_clk(8);
    bus.sclk = 1'b1; wait_clk(6); bus.sclk = 1'b0; wait_clk(3);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    m_full = 1'b0; m_buf = '0;
    chk("midrst_tx_ready", bus.tx_ready, 1);
    chk("midrst_rx_data", bus.rx_data, 0);
    chk("midrst_miso", bus.miso, 0);
    for (int i = 0; i < W; i++) begin
      bus.mosi = 1'($urandom);
      wait_clk(6); bus.sclk = 1'b1;
      wait_clk(6); bus.sclk = 1'b0;
      if (i == 2) chk("midrst_miso_low", bus.miso, 0);
    end
    chk("midrst_no_word", bus.rx_data, 0);
    bus.cs_n = 1'b1;
    wait_clk(10);
    track = 1'b1;

    // Randomized frames
    for (int t = 0; t < 25; t++) begin
      a  = W'($urandom); b = W'($urandom); c = W'($urandom);
      nw = $urandom_range(1, 3);
      lb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, W - 1) : W;
      hf = S + 2 + $urandom_range(0, 4);
      nl = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) do_load(W'($urandom));
      wait_clk($urandom_range(1, 5));
      xfer(a, b, c, nw, lb, hf, nl, W'($urandom), W'($urandom));
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    bus.rx_ack = 1'b1; wait_clk(1); bus.rx_ack = 1'b0;
    chk("overrun_cleared", bus.rx_overrun, 0);
    xfer(8'h12, '0, '0, 1, W, 6, 0, '0, '0);
    chk("overrun_first_word", bus.rx_overrun, 0);
    xfer(8'h34, '0, '0, 1, W, 6, 0, '0, '0);
    chk("overrun_second_word", bus.rx_overrun, 1);
    bus.rx_ack = 1'b1; wait_clk(1); bus.rx_ack = 1'b0;
    chk("overrun_after_ack", bus.rx_overrun, 0);
`endif

    wait_clk(20);
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("miso_queue_drained", exp_miso.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
